// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing constants for the register file
//   DATA_W   - register / ALU operand width
//   ADDR_W   - register address width
//   NUM_REGS - number of architectural registers (2**ADDR_W)
//   REG_ZERO - index of the hard-wired zero register
package regfile_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/reg_word.sv
// reg_word: one W-bit register with async active-low clear and load enable
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low clear
//   en    - load enable
//   d     - load data
//   q     - stored value
module reg_word #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/regfile.sv
// regfile: 2-read / 1-write register file with hard-wired zero register
//   clk              - rising-edge clock
//   rst_n            - asynchronous active-low reset, clears every register
//   we/waddr/wdata   - write port, registered on the rising edge
//   raddr_a/raddr_b  - read addresses
//   rdata_a/rdata_b  - combinational read data
// Macro REGFILE_BYPASS_EN: forward wdata to a read of the address being
// written in the same cycle (write-before-read); otherwise read-before-write.
module regfile #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    import regfile_pkg::REG_ZERO;

    logic [DATA_W-1:0] q [NUM_REGS];

    // Slot 0 has no storage, so writes to it vanish and it always reads zero.
    assign q[REG_ZERO] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        reg_word #(.W(DATA_W)) u_word (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (we && waddr == ADDR_W'(i)),
            .d    (wdata),
            .q    (q[i])
        );
    end

`ifdef REGFILE_BYPASS_EN
    // Gated by rst_n so nothing but zeros appears on the read ports in reset.
    logic wr_live;
    assign wr_live = rst_n && we && waddr != ADDR_W'(REG_ZERO);
    assign rdata_a = (wr_live && waddr == raddr_a) ? wdata : q[raddr_a];
    assign rdata_b = (wr_live && waddr == raddr_b) ? wdata : q[raddr_b];
`else
    assign rdata_a = q[raddr_a];
    assign rdata_b = q[raddr_b];
`endif
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile
module tb_regfile;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata, rdata_a, rdata_b;
    int n_chk = 0;
    int n_fail = 0;

    regfile dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr_a(raddr_a),
        .raddr_b(raddr_b),
        .rdata_a(rdata_a),
        .rdata_b(rdata_b)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_hz;
        rst_n = 1'b0;
        we = 1'b0;
        waddr = '0;
        wdata = '0;
        raddr_a = '0;
        raddr_b = '0;
        #2;
        // writes are ignored while reset is held
        we = 1'b1; waddr = 5'd4; wdata = 32'hCAFEF00D; raddr_a = 5'd4; raddr_b = 5'd4;
        tick();
        #1;
        chk("rst_hold_a", rdata_a, 32'h0);
        chk("rst_hold_b", rdata_b, 32'h0);
        we = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(31 - i);
            #1;
            chk($sformatf("rst_a%0d", i), rdata_a, 32'h0);
            chk($sformatf("rst_b%0d", 31 - i), rdata_b, 32'h0);
        end

        // write then read
        wr(5'd5, 32'hDEADBEEF);
        raddr_a = 5'd5; raddr_b = 5'd6;
        #1;
        chk("wr5_a", rdata_a, 32'hDEADBEEF);
        chk("wr6_b", rdata_b, 32'h0);

        // we=0 leaves registers alone
        waddr = 5'd5; wdata = 32'h01234567;
        tick();
        chk("we0_hold", rdata_a, 32'hDEADBEEF);

        // x0 protection, same cycle and after
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr_a = 5'd0; raddr_b = 5'd0;
        #1;
        chk("x0_same", rdata_a, 32'h0);
        tick();
        we = 1'b0;
        #1;
        chk("x0_next_a", rdata_a, 32'h0);
        chk("x0_next_b", rdata_b, 32'h0);

        // same-cycle read/write hazard
        wr(5'd7, 32'h11111111);
        we = 1'b1; waddr = 5'd7; wdata = 32'h22222222; raddr_a = 5'd7; raddr_b = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_hz = 32'h22222222;
`else
        exp_hz = 32'h11111111;
`endif
        chk("hz_same_a", rdata_a, exp_hz);
        chk("hz_same_b", rdata_b, exp_hz);
        tick();
        we = 1'b0;
        #1;
        chk("hz_next_a", rdata_a, 32'h22222222);
        chk("hz_next_b", rdata_b, 32'h22222222);

        // async reset mid-operation with a concurrent write
        wr(5'd3, 32'hA5A5A5A5);
        raddr_a = 5'd3; raddr_b = 5'd5;
        #1;
        chk("r3_pre", rdata_a, 32'hA5A5A5A5);
        we = 1'b1; waddr = 5'd3; wdata = 32'h12345678;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_r3", rdata_a, 32'h0);
        chk("arst_r5", rdata_b, 32'h0);
        tick();
        chk("arst_wr_lost", rdata_a, 32'h0);
        we = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("arst_after", rdata_a, 32'h0);
        // first write after release lands on the first edge
        wr(5'd3, 32'h00000055);
        chk("post_rst_wr", rdata_a, 32'h00000055);

        // full sweep
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
        for (int i = 1; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(i);
            #1;
            chk($sformatf("sw_a%0d", i), rdata_a, 32'(i) * 32'h01010101);
            chk($sformatf("sw_b%0d", i), rdata_b, 32'(i) * 32'h01010101);
        end
        raddr_a = 5'd0; raddr_b = 5'd0;
        #1;
        chk("sw_r0_a", rdata_a, 32'h0);
        chk("sw_r0_b", rdata_b, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register width in bits; it matches the ALU operand width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the register address width; NUM_REGS = 2**ADDR_W.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port we, input, 1 bit: write enable.
REQ-006 The block SHALL have port waddr, input, ADDR_W bits: write address.
REQ-007 The block SHALL have port wdata, input, DATA_W bits: write data, typically the ALU res.
REQ-008 The block SHALL have ports raddr_a and raddr_b, input, ADDR_W bits each: read addresses.
REQ-009 The block SHALL have ports rdata_a and rdata_b, output, DATA_W bits each: read data, driving ALU op_A and op_B.

Function
REQ-010 The block SHALL store NUM_REGS-1 registers of DATA_W bits, for addresses 1..NUM_REGS-1.
REQ-011 Address 0 SHALL read as all zeros at all times, and writes to address 0 SHALL be discarded.
REQ-012 Reads SHALL be combinational: rdata_a and rdata_b reflect raddr_a and raddr_b in the same cycle, with zero clock latency.
REQ-013 When we=1 and waddr!=0, the register waddr SHALL take wdata on the rising clk edge; the write is visible on the read ports from the following cycle.
REQ-014 When we=0, no register SHALL change.
REQ-015 Both read ports SHALL be independent; raddr_a==raddr_b SHALL return identical data on both ports.
REQ-016 Same-cycle read and write to the same nonzero address: the read behaviour SHALL be as defined in the Configuration section.
REQ-017 X or Z on we SHALL NOT be masked; the bench treats such a value as an error.

Reset
REQ-018 When rst_n goes low, all registers SHALL clear to zero immediately, with no dependence on clk.
REQ-019 While rst_n=0, writes SHALL be ignored and rdata_a/rdata_b SHALL read zero for every address.
REQ-020 If rst_n falls in the same cycle as a write, reset SHALL win and the register SHALL remain zero.
REQ-021 After rst_n rises, the first write SHALL take effect on the first rising clk edge at which rst_n=1 and we=1.

Configuration
REQ-022 With macro REGFILE_BYPASS_EN defined, a read whose address equals waddr, with we=1 and waddr!=0, SHALL return wdata combinationally (write-before-read).
REQ-023 Without REGFILE_BYPASS_EN, that same read SHALL return the pre-write register contents (read-before-write).
REQ-024 With REGFILE_BYPASS_EN defined, the bypass SHALL be suppressed while rst_n=0.

Structure
REQ-025 The shared package SHALL hold the constants DATA_W=32, ADDR_W=5 and NUM_REGS=32, and the register-index constant REG_ZERO=0.
REQ-026 The block SHALL use one sub-module, reg_word: a DATA_W-bit register with async active-low clear and a load enable, instantiated NUM_REGS-1 times.
REQ-027 The write decoder and the two NUM_REGS:1 read multiplexers SHALL be implemented in regfile itself.

Verification
REQ-028 The bench SHALL cover reset: drive rst_n=0, then release; every raddr 0..31 -> rdata_a=rdata_b=0x00000000.
REQ-029 The bench SHALL cover a write then read: we=1, waddr=5, wdata=0xDEADBEEF; next cycle raddr_a=5 -> 0xDEADBEEF, and raddr_b=6 -> 0.
REQ-030 The bench SHALL cover x0 protection: we=1, waddr=0, wdata=0xFFFFFFFF; next cycle raddr_a=0 -> 0x00000000.
REQ-031 The bench SHALL cover same-cycle hazard: reg 7 = 0x11111111, then we=1, waddr=7, wdata=0x22222222 with raddr_a=7 -> 0x22222222 with REGFILE_BYPASS_EN, 0x11111111 without; next cycle -> 0x22222222 in both builds.
REQ-032 The bench SHALL cover async reset mid-operation: reg 3 = 0xA5A5A5A5, then pull rst_n low between clk edges -> rdata_a (raddr_a=3) reads 0 before the next edge, and a concurrent write to reg 3 is lost.
REQ-033 The bench SHALL cover the full sweep: write reg i = i*0x01010101 for i=1..31, then read all 31 on both ports -> exact match, and reg 0 = 0.
